// File: rtl/msp_pkg.sv
// Shared types and defaults for the multi-source projector sequencer.
package msp_pkg;
  typedef enum logic [2:0] {
    IDLE, START, SETTLE, RUN, NEXT, FLUSH, DONE
  } msp_state_t;

  localparam int DEF_VERTEX_W = 48;
  localparam int DEF_COLOR_W  = 16;
  localparam int TRI_COUNT_W  = 16;
endpackage

// File: rtl/msp_src_mux.sv
// One-of-N selector over a flat packed bus; output is zero when gated off or
// when sel points past the last source.
module msp_src_mux #(
  parameter int NUM_SRC = 3,
  parameter int W       = 1,
  parameter int SEL_W   = 2
) (
  input  logic                 en,
  input  logic [SEL_W-1:0]     sel,
  input  logic [NUM_SRC*W-1:0] data,
  output logic [W-1:0]         out
);
  always_comb begin
    out = '0;
    if (en) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (int'(sel) == i) out = data[i*W +: W];
      end
    end
  end
endmodule

// File: rtl/multi_source_projector.sv
// Fixed-priority, maskable frame sequencer feeding one projection pipeline.
// Optional per-source busy watchdog enabled by defining MSP_TIMEOUT_EN.
module multi_source_projector
  import msp_pkg::*;
#(
  parameter int NUM_SRC  = 3,
  parameter int VERTEX_W = DEF_VERTEX_W,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int TIMEOUT  = 4096
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_req,
  input  logic [NUM_SRC-1:0]         src_enable,
  output logic [NUM_SRC-1:0]         src_start,
  input  logic [NUM_SRC-1:0]         src_busy,
  input  logic [NUM_SRC*VERTEX_W-1:0] src_vertex,
  input  logic [NUM_SRC*COLOR_W-1:0] src_color,
  input  logic [NUM_SRC-1:0]         src_new_tri,
  output logic [VERTEX_W-1:0]        vertex,
  output logic [COLOR_W-1:0]         color,
  output logic                       new_triangle,
  output logic                       proj_flush,
  input  logic                       proj_done,
  output logic [TRI_COUNT_W-1:0]     tri_count,
  output logic                       done_out,
  output logic [NUM_SRC-1:0]         timeout_err
);
  // idx must be able to hold NUM_SRC so the scan can run off the end.
  localparam int IDX_W = $clog2(NUM_SRC + 1);

  if (NUM_SRC < 1 || NUM_SRC > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("multi_source_projector: illegal NUM_SRC or TIMEOUT");
  end

  msp_state_t         state, state_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic [NUM_SRC-1:0] mask;
  logic               scan_hit;
  logic [IDX_W-1:0]   scan_idx;
  logic               mux_en, sel_busy, to_hit;

  assign mux_en = (state == SETTLE) || (state == RUN);

  msp_src_mux #(.NUM_SRC(NUM_SRC), .W(VERTEX_W), .SEL_W(IDX_W)) u_mux_vtx (
    .en(mux_en), .sel(idx), .data(src_vertex), .out(vertex));
  msp_src_mux #(.NUM_SRC(NUM_SRC), .W(COLOR_W), .SEL_W(IDX_W)) u_mux_col (
    .en(mux_en), .sel(idx), .data(src_color), .out(color));
  msp_src_mux #(.NUM_SRC(NUM_SRC), .W(1), .SEL_W(IDX_W)) u_mux_tri (
    .en(mux_en), .sel(idx), .data(src_new_tri), .out(new_triangle));
  msp_src_mux #(.NUM_SRC(NUM_SRC), .W(1), .SEL_W(IDX_W)) u_mux_busy (
    .en(1'b1), .sel(idx), .data(src_busy), .out(sel_busy));

  // Lowest enabled source at or above idx, found in a single cycle.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (mask[i] && int'(idx) <= i) begin
        scan_hit = 1'b1;
        scan_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE:   if (frame_req) begin state_nx = NEXT; idx_nx = '0; end
      NEXT:   if (scan_hit) begin state_nx = START; idx_nx = scan_idx; end
              else state_nx = FLUSH;
      START:  state_nx = SETTLE;
      SETTLE: state_nx = RUN;
      RUN:    if (!sel_busy || to_hit) begin
                state_nx = NEXT;
                idx_nx   = idx + 1'b1;
              end
      FLUSH:  if (proj_done) state_nx = DONE;
      DONE:   if (!frame_req) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      mask       <= '0;
      src_start  <= '0;
      proj_flush <= 1'b0;
      done_out   <= 1'b0;
      tri_count  <= '0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      proj_flush <= (state_nx == FLUSH);
      done_out   <= (state_nx == DONE);
      src_start  <= '0;
      if (state == START) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (int'(idx) == i) src_start[i] <= 1'b1;
        end
      end
      if (state == IDLE && frame_req) begin
        mask      <= src_enable;
        tri_count <= '0;
      end else if (new_triangle && tri_count != '1) begin
        tri_count <= tri_count + 1'b1;
      end
    end
  end

`ifdef MSP_TIMEOUT_EN
  logic [31:0] to_cnt;

  assign to_hit = (state == RUN) && sel_busy && (to_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= '0;
    end else if (state == RUN && sel_busy) begin
      if (to_hit) begin
        to_cnt <= '0;
        for (int i = 0; i < NUM_SRC; i++) begin
          if (int'(idx) == i) timeout_err[i] <= 1'b1;
        end
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = '0;
`endif
endmodule

// File: doc/multi_source_projector.md
# multi_source_projector

Frame-level sequencer that drives one shared 3D projection pipeline from `NUM_SRC` independent triangle sources (obstacles, player sprite, scenery, HUD, …). It replaces the fixed two-source obstacle→sprite sequencing with a parametrised, maskable, fixed-priority walk over all sources. After the walk it flushes the projector and holds a level `done_out` handshake toward the frame controller. It sits between the per-object triangle creators and `ddd_projector`.

## Interface
- `NUM_SRC`, 3: number of triangle sources; legal range 1..8.
- `VERTEX_W`, 48: vertex bus width (3×16 signed).
- `COLOR_W`, 16: colour width.
- `TIMEOUT`, 4096: per-source busy watchdog limit in cycles (used only with the macro).
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `frame_req` in 1: level; high requests a frame; must drop to end it.
- `src_enable` in NUM_SRC: mask, sampled in IDLE on frame acceptance.
- `src_start` out NUM_SRC: one-cycle start pulse to source i.
- `src_busy` in NUM_SRC: source i is emitting vertices.
- `src_vertex` in NUM_SRC×VERTEX_W: packed; source i at `[i*VERTEX_W +: VERTEX_W]`.
- `src_color` in NUM_SRC×COLOR_W: packed, same scheme.
- `src_new_tri` in NUM_SRC: first vertex of a new triangle.
- `vertex` out VERTEX_W, `color` out COLOR_W, `new_triangle` out 1: to the projector.
- `proj_flush` out 1: level; asks the projector to drain.
- `proj_done` in 1: projector drained.
- `tri_count` out 16: triangles forwarded this frame; saturates at 0xFFFF.
- `done_out` out 1: frame complete; held until `frame_req` is low.
- `timeout_err` out NUM_SRC: sticky per-source watchdog flags (macro only; otherwise tied 0).

## Operation
- States: IDLE, START, SETTLE, RUN, NEXT, FLUSH, DONE.
- IDLE:
  - If `frame_req` is high, latch `src_enable` into `mask`, set `idx`=0, clear `tri_count` and go to NEXT.
  - `frame_req` already high on exit from reset starts a frame.
- NEXT: scan upward from `idx`.
  - On the first i ≥ idx with `mask[i]`, set idx=i and go to START.
  - If none is found, go to FLUSH. The scan is combinational and takes one cycle regardless of the number of skipped sources.
- START: pulse `src_start[idx]` for exactly one cycle, then go to SETTLE.
- SETTLE: one cycle to allow `src_busy` to rise, then go to RUN.
- RUN: exit when `src_busy[idx]` is low; set idx=idx+1 and go to NEXT. A source that never raises busy therefore costs 4 cycles.
- FLUSH: `proj_flush` is high every cycle. When `proj_done` is sampled high, go to DONE.
- DONE:
  - `done_out` is high.
  - When `frame_req` is low, drive `done_out` low in that same registered update and return to IDLE.
- Mux:
  - In SETTLE and RUN, `vertex`/`color`/`new_triangle` equal source idx (combinational).
  - Otherwise all three are 0.
  - Inputs from non-selected sources are ignored, including simultaneous `src_new_tri` assertions.
- `tri_count` increments on each cycle where the muxed `new_triangle` is high.
- `frame_req` deasserting before DONE is ignored; the frame always completes.
- `src_enable` changes mid-frame are ignored.
- An all-zero mask goes IDLE→NEXT→FLUSH.

## Timing
- Reset values: `src_start`=0, `proj_flush`=0, `done_out`=0, `tri_count`=0, `timeout_err`=0, mux outputs 0. State is IDLE.
- Reset mid-frame aborts immediately; no flush is issued.
- All control outputs are registered; mux outputs are combinational from the registered state and idx.
- Cycle timing, with `frame_req` rising at cycle 0 and source 0 enabled:
  - cycle 1: NEXT
  - cycle 2: START
  - cycle 3: `src_start[0]` visible; SETTLE
  - cycle 4: RUN
- Sources must hold busy high from the cycle after `src_start` until their final vertex.
- Projector latency is unconstrained; `proj_done` must not be asserted before `proj_flush`.

## Configuration
- `MSP_TIMEOUT_EN` defined:
  - A counter runs while in RUN.
  - If `src_busy[idx]` stays high for `TIMEOUT` cycles, set `timeout_err[idx]` and force NEXT.
  - Flags clear only on `rst`.
- Not defined: no counter, `timeout_err` is constant 0, and RUN waits indefinitely.

## Structure
- Package `msp_pkg`: state enum `msp_state_t`, `VERTEX_W`/`COLOR_W` defaults, `TRI_COUNT_W`=16.
- Sub-module `msp_src_mux`: parametrised NUM_SRC one-of-N selector with a gating enable. It is reused by the mux outputs and by `src_busy` selection.

## Test plan
- NUM_SRC=3, mask 3'b111, each source busy for 5 cycles emitting 2 triangles → starts in order 0,1,2; `tri_count`=6; `proj_flush` then `done_out`.
- Mask 3'b101 → `src_start[1]` never pulses; the NEXT scan skips source 1 in one cycle; `tri_count` counts only sources 0 and 2.
- Mask 3'b000 → no `src_start`; FLUSH is reached at cycle 2; `done_out` follows `proj_done`.
- Source 1 asserts `src_new_tri` while source 0 is in RUN → ignored; `tri_count` is unchanged by it.
- `frame_req` held high 20 cycles after `done_out` → `done_out` stays high; it drops the cycle after `frame_req` falls; `rst` during RUN clears all outputs next cycle.
- With `MSP_TIMEOUT_EN`, TIMEOUT=16, source 0 busy forever → `timeout_err`=3'b001 after 16 RUN cycles; source 1 starts next.
